// File: rtl/tmr_cmp_bank.sv
// tmr_cmp_bank: a bank of NUM_CH timer-compare channels on the register bus.
// Each channel compares its CMP register with the shared timer count on every
// count tick. On a match it sets a sticky pending flag, then either reloads CMP
// by PERIOD (periodic mode) or disables itself (one-shot mode).
// Pending flags that have their interrupt enabled are OR-ed into one
// registered irq output.
module tmr_cmp_bank #(
  parameter int unsigned          NUM_CH    = 4,
  parameter int unsigned          DW        = 32,
  parameter int unsigned          ADDR_W    = 13,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = 13'h100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  input  logic [DW-1:0]     cnt,
  input  logic              cnt_tick,
  output logic              irq
);

  // Per-channel control bits, laid out exactly as they appear on the bus.
  typedef struct packed {
    logic ie;
    logic periodic;
    logic en;
  } ctrl_t;

  localparam logic [ADDR_W-1:0] STATUS_ADDR = BASE_ADDR + ADDR_W'(16 * NUM_CH);

  // Byte address of register 'off' inside channel 'ch'.
  function automatic logic [ADDR_W-1:0] reg_addr(input int unsigned ch,
                                                 input int unsigned off);
    return BASE_ADDR + ADDR_W'(16 * ch + off);
  endfunction

  // Architectural state.
  logic [DW-1:0]     cmp_q    [NUM_CH];
  logic [DW-1:0]     cmp_d    [NUM_CH];
  logic [DW-1:0]     period_q [NUM_CH];
  logic [DW-1:0]     period_d [NUM_CH];
  ctrl_t             ctrl_q   [NUM_CH];
  ctrl_t             ctrl_d   [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              irq_q, irq_d;

  // Bus decode and match results.
  logic [NUM_CH-1:0] wr_cmp, wr_period, wr_ctrl;
  logic [NUM_CH-1:0] w1c_mask;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] ie_vec;
  logic [31:0]       rd_sel;

  // Decode the bus address into per-channel write strobes and the W1C mask.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so that no path
    // through the block leaves a value unassigned and infers a latch.
    wr_cmp    = '0;
    wr_period = '0;
    wr_ctrl   = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      wr_cmp[n]    = wr_en && (addr == reg_addr(n, 0));
      wr_period[n] = wr_en && (addr == reg_addr(n, 4));
      wr_ctrl[n]   = wr_en && (addr == reg_addr(n, 8));
    end
    w1c_mask = (wr_en && (addr == STATUS_ADDR)) ? wr_data[NUM_CH-1:0] : '0;
  end

  // A match needs a fresh count value, so a stalled counter cannot re-trigger.
  always_comb begin
    hit    = '0;
    ie_vec = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      hit[n]    = cnt_tick && ctrl_q[n].en && (cnt == cmp_q[n]);
      ie_vec[n] = ctrl_q[n].ie;
    end
  end

  // Read mux: unmapped addresses and bits above the register width read 0.
  always_comb begin
    rd_sel = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (addr == reg_addr(n, 0)) rd_sel[DW-1:0] = cmp_q[n];
      if (addr == reg_addr(n, 4)) rd_sel[DW-1:0] = period_q[n];
      if (addr == reg_addr(n, 8)) rd_sel[2:0]    = ctrl_q[n];
    end
    if (addr == STATUS_ADDR) rd_sel[NUM_CH-1:0] = pending_q;
  end

  // Next state: hardware events first, so that a bus write on the same cycle overrides them.
  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      cmp_d[n]    = cmp_q[n];
      period_d[n] = period_q[n];
      ctrl_d[n]   = ctrl_q[n];
      if (hit[n]) begin
        if (ctrl_q[n].periodic) begin
          cmp_d[n] = cmp_q[n] + period_q[n];
        end else begin
          ctrl_d[n].en = 1'b0;
        end
      end
      if (wr_cmp[n])    cmp_d[n]    = wr_data[DW-1:0];
      if (wr_period[n]) period_d[n] = wr_data[DW-1:0];
      if (wr_ctrl[n])   ctrl_d[n]   = ctrl_t'(wr_data[2:0]);
    end
    // A new hit wins over a W1C of the same pending bit.
    pending_d = (pending_q & ~w1c_mask) | hit;
    irq_d     = |(pending_q & ie_vec);
    rd_data_d = rd_en ? rd_sel : rd_data_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the clock edge, whatever the statement order.
    if (!rst_n) begin
      // NOTE: the register arrays are reset explicitly. They are small flop
      // arrays, not RAM, and software relies on CMP starting at all ones.
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cmp_q[n]    <= '1;
        period_q[n] <= '0;
        ctrl_q[n]   <= '0;
      end
      pending_q <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule
